dest_reg_pipeline: RTL and testbench
====================================

DEST_REG_PIPELINE -- requirements
Module: dest_reg_pipeline

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the register-address width.
REQ-002 The block SHALL have parameter LINK_REG, default 31, meaning the destination used in link (JAL/JALR) mode.
REQ-003 The block SHALL have one clock and a reset that is synchronous and active-high; the ports are clk and rst.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port rt_e, input, ADDR_W bits: Rt field in the EX stage.
REQ-007 Port rd_e, input, ADDR_W bits: Rd field in the EX stage.
REQ-008 Port reg_dst_e, input, 2 bits: destination mode (00 Rt, 01 Rd, 10 LINK_REG, 11 reserved).
REQ-009 Port reg_write_e, input, 1 bit: the EX-stage instruction writes the register file.
REQ-010 Port stall, input, 1 bit: hold the EX/MEM and MEM/WB destination registers.
REQ-011 Port flush, input, 1 bit: insert a bubble into the EX/MEM register.
REQ-012 Port src_a, input, ADDR_W bits: Rs of the EX-stage instruction, used for the forwarding compare.
REQ-013 Port src_b, input, ADDR_W bits: Rt of the EX-stage instruction, used for the forwarding compare.
REQ-014 Port write_reg_e, output, ADDR_W bits: selected destination, combinational.
REQ-015 Port write_reg_m / reg_write_m, output, ADDR_W / 1 bits: registered MEM-stage destination and write enable.
REQ-016 Port write_reg_w / reg_write_w, output, ADDR_W / 1 bits: registered WB-stage destination and write enable.
REQ-017 Port fwd_a / fwd_b, output, 2 bits each: forwarding select (00 register file, 10 from MEM, 01 from WB).

Function
REQ-018 write_reg_e SHALL equal rt_e for mode 00, rd_e for mode 01, LINK_REG (truncated to ADDR_W) for mode 10, and 0 for mode 11, all in the same cycle.
REQ-019 The effective EX write enable SHALL be reg_write_e AND mode!=11 AND write_reg_e!=0; writes to register 0 never propagate as valid.
REQ-020 If neither rst, stall nor flush is asserted, then at each edge {write_reg_m, reg_write_m} SHALL load {write_reg_e, effective enable} and {write_reg_w, reg_write_w} SHALL load the old MEM values; latency EX->MEM is 1 cycle, EX->WB is 2 cycles.
REQ-021 If flush is asserted and stall is not, then write_reg_m SHALL load 0 and reg_write_m SHALL load 0, and the WB stage SHALL advance normally.
REQ-022 If stall is asserted and flush is not, then the MEM and WB registers SHALL hold their values.
REQ-023 If stall and flush are asserted together, then the MEM stage SHALL take the bubble (0/0) and the WB stage SHALL hold; flush has priority for the MEM stage only.
REQ-024 fwd_a SHALL be 10 when reg_write_m=1 and write_reg_m==src_a!=0.
REQ-025 fwd_a SHALL otherwise be 01 when reg_write_w=1 and write_reg_w==src_a!=0, and SHALL otherwise be 00; MEM has priority over WB.
REQ-026 fwd_b SHALL follow the same rule as fwd_a, using src_b.
REQ-027 fwd_a and fwd_b SHALL be combinational from the current registered state and the src inputs, with no added latency.
REQ-028 All widths SHALL derive from ADDR_W, with no hard-coded 5-bit slices.

Reset
REQ-029 On an edge with rst=1, write_reg_m, reg_write_m, write_reg_w and reg_write_w SHALL all become 0, regardless of stall or flush.
REQ-030 After reset, fwd_a and fwd_b SHALL read 00 until a valid write enters the pipeline.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight destinations, and the first post-reset instruction SHALL reach MEM one edge after rst deasserts.

Verification
REQ-032 Mode select: rt_e=8, rd_e=9; drive modes 00/01/10/11 -> write_reg_e = 8/9/31/0, and mode 11 yields reg_write_m=0 after the edge.
REQ-033 Pipeline timing: reg_dst_e=01, rd_e=5, reg_write_e=1 at cycle 0 -> write_reg_m=5 at cycle 1 and write_reg_w=5 at cycle 2, each with its enable at 1.
REQ-034 Forward priority: MEM holds dest 7 valid, WB holds dest 7 valid, src_a=7 -> fwd_a=10; once MEM is a bubble -> fwd_a=01; with src_a=0 -> fwd_a=00.
REQ-035 Stall/flush: MEM=4, WB=3 with stall=1 and flush=1 -> after the edge MEM=0/0 and WB=3/1; with stall alone -> both held.
REQ-036 Register-zero write: reg_write_e=1, reg_dst_e=00, rt_e=0 -> reg_write_m=0 and no forwarding when src_a=0.
REQ-037 Reset mid-flight: MEM=12/1, WB=6/1, rst=1 for one edge -> all four registered outputs become 0 and fwd_a=fwd_b=00.

Source files
------------

// File: rtl/dest_reg_pipeline_if.sv
// EX-stage destination/forwarding bus between the decode/hazard logic and the
// destination register pipeline.
interface dest_reg_pipeline_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rt_e;
   logic [ADDR_W-1:0] rd_e;
   logic [1:0]        reg_dst_e;
   logic              reg_write_e;
   logic              stall;
   logic              flush;
   logic [ADDR_W-1:0] src_a;
   logic [ADDR_W-1:0] src_b;
   logic [ADDR_W-1:0] write_reg_e;
   logic [ADDR_W-1:0] write_reg_m;
   logic              reg_write_m;
   logic [ADDR_W-1:0] write_reg_w;
   logic              reg_write_w;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   modport master (
      output rt_e, rd_e, reg_dst_e, reg_write_e, stall, flush, src_a, src_b,
      input  write_reg_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w,
             fwd_a, fwd_b
   );

   modport slave (
      input  rt_e, rd_e, reg_dst_e, reg_write_e, stall, flush, src_a, src_b,
      output write_reg_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w,
             fwd_a, fwd_b
   );
endinterface

// File: rtl/dest_reg_pipeline.sv
// Destination register select for EX, EX->MEM->WB destination pipeline, and
// MEM/WB forwarding selects for the two EX source operands.
module dest_reg_pipeline #(
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = 31
) (
   input  logic clk,
   input  logic rst,
   dest_reg_pipeline_if.slave bus
);
   localparam logic [ADDR_W-1:0] LINK = LINK_REG[ADDR_W-1:0];

   logic [ADDR_W-1:0] w_write_reg_e;
   logic              w_we_e;
   logic [ADDR_W-1:0] r_write_reg_m;
   logic              r_reg_write_m;
   logic [ADDR_W-1:0] r_write_reg_w;
   logic              r_reg_write_w;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;

   always_comb begin
      w_write_reg_e = '0;
      case (bus.reg_dst_e)
         2'b00:   w_write_reg_e = bus.rt_e;
         2'b01:   w_write_reg_e = bus.rd_e;
         2'b10:   w_write_reg_e = LINK;
         default: w_write_reg_e = '0;
      endcase
   end

   // Register 0 is hardwired, so a write to it must never look valid downstream.
   assign w_we_e = bus.reg_write_e && (bus.reg_dst_e != 2'b11) && (w_write_reg_e != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_write_reg_m <= '0;
         r_reg_write_m <= 1'b0;
         r_write_reg_w <= '0;
         r_reg_write_w <= 1'b0;
      end else begin
         if (bus.flush) begin
            r_write_reg_m <= '0;
            r_reg_write_m <= 1'b0;
         end else if (!bus.stall) begin
            r_write_reg_m <= w_write_reg_e;
            r_reg_write_m <= w_we_e;
         end
         if (!bus.stall) begin
            r_write_reg_w <= r_write_reg_m;
            r_reg_write_w <= r_reg_write_m;
         end
      end
   end

   // MEM is the younger result, so it wins over WB.
   always_comb begin
      w_fwd_a = 2'b00;
      if (bus.src_a != '0) begin
         if (r_reg_write_m && (r_write_reg_m == bus.src_a))      w_fwd_a = 2'b10;
         else if (r_reg_write_w && (r_write_reg_w == bus.src_a)) w_fwd_a = 2'b01;
      end
   end

   always_comb begin
      w_fwd_b = 2'b00;
      if (bus.src_b != '0) begin
         if (r_reg_write_m && (r_write_reg_m == bus.src_b))      w_fwd_b = 2'b10;
         else if (r_reg_write_w && (r_write_reg_w == bus.src_b)) w_fwd_b = 2'b01;
      end
   end

   assign bus.write_reg_e = w_write_reg_e;
   assign bus.write_reg_m = r_write_reg_m;
   assign bus.reg_write_m = r_reg_write_m;
   assign bus.write_reg_w = r_write_reg_w;
   assign bus.reg_write_w = r_reg_write_w;
   assign bus.fwd_a       = w_fwd_a;
   assign bus.fwd_b       = w_fwd_b;
endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Scoreboard bench: driver pushes expected combinational and registered
// responses from a two-slot stage model; monitor pops and compares.
module tb_dest_reg_pipeline;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dest_reg_pipeline_if #(.ADDR_W(AW)) bus ();

   dest_reg_pipeline #(.ADDR_W(AW), .LINK_REG(31)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [AW-1:0] d;
      logic          v;
   } slot_t;

   typedef struct {
      logic [AW-1:0] wre;
      logic [1:0]    fa;
      logic [1:0]    fb;
      bit            chk_fwd;
   } comb_exp_t;

   typedef struct {
      logic [AW-1:0] wrm;
      logic          rwm;
      logic [AW-1:0] wrw;
      logic          rww;
   } reg_exp_t;

   comb_exp_t q_comb[$];
   reg_exp_t  q_reg[$];

   // stage[0] = MEM, stage[1] = WB
   slot_t stage[2];
   bit    known = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    done  = 0;

   function automatic logic [AW-1:0] pick_dest(input logic [1:0] mode,
                                               input logic [AW-1:0] rt,
                                               input logic [AW-1:0] rd);
      if (mode == 2'd0) return rt;
      if (mode == 2'd1) return rd;
      if (mode == 2'd2) return AW'(31);
      return '0;
   endfunction

   function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
      if (src == 0) return 2'b00;
      for (int i = 0; i < 2; i++)
         if (stage[i].v && stage[i].d == src) return (i == 0) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input logic [1:0] mode, input bit we, input bit st, input bit fl,
                       input logic [AW-1:0] sa, input logic [AW-1:0] sb);
      comb_exp_t ce;
      reg_exp_t  re;
      slot_t     nm, nw, ins;
      @(negedge clk);
      rst = r;
      bus.rt_e = rt; bus.rd_e = rd; bus.reg_dst_e = mode; bus.reg_write_e = we;
      bus.stall = st; bus.flush = fl; bus.src_a = sa; bus.src_b = sb;
      ce.wre     = pick_dest(mode, rt, rd);
      ce.chk_fwd = known;
      ce.fa      = model_fwd(sa);
      ce.fb      = model_fwd(sb);
      q_comb.push_back(ce);
      ins.d = ce.wre;
      ins.v = we && (mode != 2'd3) && (ins.d != 0);
      if (r) begin
         nm = '{d: '0, v: 1'b0};
         nw = '{d: '0, v: 1'b0};
         known = 1;
      end else begin
         nw = st ? stage[1] : stage[0];
         nm = fl ? '{d: '0, v: 1'b0} : (st ? stage[0] : ins);
      end
      stage[0] = nm;
      stage[1] = nw;
      re = '{wrm: nm.d, rwm: nm.v, wrw: nw.d, rww: nw.v};
      if (known) q_reg.push_back(re);
   endtask

   task automatic issue(input logic [AW-1:0] d, input logic [AW-1:0] sa);
      step(0, d, 5'd0, 2'b00, 1, 0, 0, sa, 5'd0);
   endtask

   // Monitor: combinational outputs mid-low-phase, registered outputs after the edge.
   initial begin
      comb_exp_t ce;
      reg_exp_t  re;
      forever begin
         @(negedge clk);
         #2;
         if (q_comb.size() > 0) begin
            ce = q_comb.pop_front();
            check("write_reg_e", 8'(bus.write_reg_e), 8'(ce.wre));
            if (ce.chk_fwd) begin
               check("fwd_a", 8'(bus.fwd_a), 8'(ce.fa));
               check("fwd_b", 8'(bus.fwd_b), 8'(ce.fb));
            end
         end
         @(posedge clk);
         #1;
         if (q_reg.size() > 0) begin
            re = q_reg.pop_front();
            check("write_reg_m", 8'(bus.write_reg_m), 8'(re.wrm));
            check("reg_write_m", 8'(bus.reg_write_m), 8'(re.rwm));
            check("write_reg_w", 8'(bus.write_reg_w), 8'(re.wrw));
            check("reg_write_w", 8'(bus.reg_write_w), 8'(re.rww));
         end
      end
   end

   initial begin
      bus.rt_e = '0; bus.rd_e = '0; bus.reg_dst_e = '0; bus.reg_write_e = 0;
      bus.stall = 0; bus.flush = 0; bus.src_a = '0; bus.src_b = '0;

      // reset, then reset state must show no forwarding
      step(1, 5'd3, 5'd4, 2'b00, 1, 1, 1, 5'd3, 5'd4);
      step(1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0);
      step(0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd3, 5'd4);

      // mode select: 8 / 9 / 31 / 0
      for (int m = 0; m < 4; m++) step(0, 5'd8, 5'd9, 2'(m), 1, 0, 0, 5'd8, 5'd31);
      step(0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd9, 5'd0);

      // EX->MEM->WB latency
      step(0, 5'd0, 5'd5, 2'b01, 1, 0, 0, 5'd0, 5'd0);
      step(0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd5, 5'd0);
      step(0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd5);

      // forward priority: MEM over WB, then WB after MEM bubble, then src 0
      issue(5'd7, 5'd0);
      issue(5'd7, 5'd0);
      step(0, 5'd0, 5'd0, 2'b00, 0, 1, 1, 5'd7, 5'd7);
      step(0, 5'd0, 5'd0, 2'b00, 0, 1, 0, 5'd7, 5'd7);
      step(0, 5'd0, 5'd0, 2'b00, 0, 1, 0, 5'd0, 5'd7);

      // stall+flush and stall alone
      issue(5'd3, 5'd0);
      issue(5'd4, 5'd0);
      step(0, 5'd9, 5'd0, 2'b00, 1, 1, 1, 5'd4, 5'd3);
      issue(5'd4, 5'd3);
      step(0, 5'd9, 5'd0, 2'b00, 1, 1, 0, 5'd4, 5'd3);
      step(0, 5'd0, 5'd0, 2'b00, 0, 1, 0, 5'd4, 5'd3);

      // register-zero write never valid
      step(0, 5'd0, 5'd0, 2'b00, 1, 0, 0, 5'd0, 5'd0);
      step(0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0);

      // reset mid-flight
      issue(5'd6, 5'd0);
      issue(5'd12, 5'd6);
      step(1, 5'd2, 5'd0, 2'b00, 1, 1, 0, 5'd12, 5'd6);
      step(0, 5'd2, 5'd0, 2'b00, 1, 0, 0, 5'd12, 5'd6);
      step(0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 5'd2, 5'd0);

      // randomized traffic, small register range for frequent hazards
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 39) == 0),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

      // drain with a bounded wait
      for (int i = 0; i < 10 && (q_comb.size() > 0 || q_reg.size() > 0); i++) @(negedge clk);
      @(negedge clk);
      if (q_comb.size() > 0 || q_reg.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q_comb.size(), q_reg.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
